// File: rtl/multi_button_led_ctrl.sv
// Purpose  : N-channel push-button front end: synchroniser, counter debouncer,
//            press/release event pulses and per-channel toggle/momentary LED drive.
// Latency  : clean button edge -> pressed_o after SYNC_STAGES+DEBOUNCE_CYCLES cycles;
//            press_o/release_o/led_o update one cycle after pressed_o.
// Backpressure: none; free-running pin-level front end, events are 1-cycle pulses.
//
// Optional feature macro: LONG_PRESS_EN
//   defined   -> per-channel hold counter and long_press_o port are built.
//   undefined -> no hold counters, no long_press_o port, LONG_CYCLES unused.
//
// Ports:
//   sysclk        system clock, all logic on rising edge
//   rst           synchronous active-high reset
//   btn_i         raw asynchronous button pins (polarity set by ACTIVE_LOW)
//   mode_i        per channel: 0 = toggle LED on press, 1 = LED follows pressed state
//   led_o         LED drive, 1 = on
//   press_o       1-cycle pulse per accepted press
//   release_o     1-cycle pulse per accepted release
//   pressed_o     debounced level, 1 = pressed
//   long_press_o  1-cycle pulse once per hold of LONG_CYCLES (LONG_PRESS_EN only)

module multi_button_led_ctrl #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned LONG_CYCLES     = 2000000
) (
  input  logic            sysclk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  input  logic [N_CH-1:0] mode_i,
  output logic [N_CH-1:0] led_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] pressed_o
`ifdef LONG_PRESS_EN
  ,
  output logic [N_CH-1:0] long_press_o
`endif
);

  // Debounce counter only ever counts up to DEBOUNCE_CYCLES-1 before it is
  // cleared, so this width leaves no reachable wrap.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time sanity check on the configuration.
  localparam bit PARAMS_OK = (N_CH >= 1) && (SYNC_STAGES >= 2) &&
                             (DEBOUNCE_CYCLES >= 1) && (LONG_CYCLES >= 1);
  if (!PARAMS_OK) begin : g_param_check
    $fatal(1, "multi_button_led_ctrl: illegal parameter set");
  end

  // Normalise pin polarity so everything downstream sees pressed = 1.
  // The sync chain resets to 0, i.e. the released level.
  logic [N_CH-1:0] btn_norm;
  assign btn_norm = ACTIVE_LOW ? ~btn_i : btn_i;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   pressed_q;
    logic                   pressed_d_q;  // pressed_q one cycle late, for edge detect
    logic                   press_q;
    logic                   release_q;
    logic                   led_q;
    logic                   sync_s;
    logic                   rise;
    logic                   fall;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = pressed_q & ~pressed_d_q;
    assign fall   = ~pressed_q & pressed_d_q;

    // Synchroniser chain: bit 0 samples the pin, top bit feeds the debouncer.
    always_ff @(posedge sysclk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_norm[ch]};
      end
    end

    // Debouncer: the synchronised input must disagree with the accepted
    // level for DEBOUNCE_CYCLES consecutive cycles before it is taken.
    // Any cycle of agreement (a bounce back) restarts the count.
    always_ff @(posedge sysclk) begin
      if (rst) begin
        cnt_q     <= '0;
        pressed_q <= 1'b0;
      end else if (sync_s == pressed_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q     <= '0;
        pressed_q <= sync_s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    // Registered event pulses, one cycle after the debounced level moves.
    always_ff @(posedge sysclk) begin
      if (rst) begin
        pressed_d_q <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
      end else begin
        pressed_d_q <= pressed_q;
        press_q     <= rise;
        release_q   <= fall;
      end
    end

    // LED drive, aligned with the event pulses. Toggle mode only reacts to
    // a press, so switching from momentary to toggle simply freezes the LED;
    // switching to momentary picks up the debounced level on the next edge.
    always_ff @(posedge sysclk) begin
      if (rst) begin
        led_q <= 1'b0;
      end else if (mode_i[ch]) begin
        led_q <= pressed_q;
      end else if (rise) begin
        led_q <= ~led_q;
      end
    end

    assign led_o[ch]     = led_q;
    assign press_o[ch]   = press_q;
    assign release_o[ch] = release_q;
    assign pressed_o[ch] = pressed_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q;
    logic              long_done_q;  // pulse already issued for this hold
    logic              long_q;

    // Hold counter saturates at LONG_CYCLES; the pulse fires on the first
    // cycle the saturated value is seen, and release re-arms it. The LED is
    // untouched here, so a long press never causes a second toggle.
    always_ff @(posedge sysclk) begin
      if (rst) begin
        hold_q      <= '0;
        long_done_q <= 1'b0;
        long_q      <= 1'b0;
      end else if (!pressed_q) begin
        hold_q      <= '0;
        long_done_q <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        if (hold_q != HOLD_MAX) begin
          hold_q <= hold_q + HOLD_W'(1);
        end
        long_q <= (hold_q == HOLD_MAX) && !long_done_q;
        if (hold_q == HOLD_MAX) begin
          long_done_q <= 1'b1;
        end
      end
    end

    assign long_press_o[ch] = long_q;
`endif

  end : g_ch

endmodule

// File: tb/tb_multi_button_led_ctrl.sv
module tb_multi_button_led_ctrl;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [3:0] btn_i;
  logic [3:0] mode_i;
  logic [3:0] led_o;
  logic [3:0] press_o;
  logic [3:0] release_o;
  logic [3:0] pressed_o;
`ifdef LONG_PRESS_EN
  logic [3:0] long_press_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  multi_button_led_ctrl #(
    .N_CH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW(1'b1),
    .LONG_CYCLES(32)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .btn_i(btn_i),
    .mode_i(mode_i),
    .led_o(led_o),
    .press_o(press_o),
    .release_o(release_o),
    .pressed_o(pressed_o)
`ifdef LONG_PRESS_EN
    ,
    .long_press_o(long_press_o)
`endif
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_i  = 4'hF;
    mode_i = 4'b0000;

    // Reset held 3 cycles with buttons released
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_led", led_o, 4'b0000);
      check("rst_press", press_o, 4'b0000);
      check("rst_pressed", pressed_o, 4'b0000);
    end
    rst = 1'b0;
    tick(5);
    check("post_rst_led", led_o, 4'b0000);
    check("post_rst_press", press_o, 4'b0000);
    check("post_rst_release", release_o, 4'b0000);
    check("post_rst_pressed", pressed_o, 4'b0000);

    // ch0 toggle mode: press held 20 cycles
    btn_i = 4'b1110;
    tick(9);
    check("ch0_pressed_e9", pressed_o, 4'b0000);
    tick(1);
    check("ch0_pressed_e10", pressed_o, 4'b0001);
    check("ch0_press_e10", press_o, 4'b0000);
    tick(1);
    check("ch0_press_e11", press_o, 4'b0001);
    check("ch0_led_e11", led_o, 4'b0001);
    tick(1);
    check("ch0_press_e12", press_o, 4'b0000);
    tick(8);
    btn_i = 4'hF;
    tick(10);
    check("ch0_rel_pressed", pressed_o, 4'b0000);
    check("ch0_rel_early", release_o, 4'b0000);
    tick(1);
    check("ch0_release", release_o, 4'b0001);
    check("ch0_led_after_rel", led_o, 4'b0001);
    tick(1);
    check("ch0_release_end", release_o, 4'b0000);
    // second press toggles LED off
    btn_i = 4'b1110;
    tick(11);
    check("ch0_press2", press_o, 4'b0001);
    check("ch0_led_toggle_off", led_o, 4'b0000);
    btn_i = 4'hF;
    tick(12);
    check("ch0_idle", pressed_o, 4'b0000);

    // ch1 bounce: low 5, high 2, low 5, high -> never accepted
    btn_i = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bounce_pressed_a", pressed_o, 4'b0000);
      check("bounce_press_a", press_o, 4'b0000);
    end
    btn_i = 4'hF;
    tick(2);
    check("bounce_pressed_b", pressed_o, 4'b0000);
    btn_i = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bounce_pressed_c", pressed_o, 4'b0000);
      check("bounce_press_c", press_o, 4'b0000);
    end
    btn_i = 4'hF;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      check("bounce_pressed_d", pressed_o, 4'b0000);
      check("bounce_press_d", press_o, 4'b0000);
    end

    // ch2 momentary mode: 30-cycle press
    mode_i = 4'b0100;
    btn_i  = 4'b1011;
    tick(10);
    check("ch2_pressed", pressed_o, 4'b0100);
    check("ch2_led_lag", led_o, 4'b0000);
    tick(1);
    check("ch2_led_on", led_o, 4'b0100);
    check("ch2_press", press_o, 4'b0100);
    tick(19);
    btn_i = 4'hF;
    tick(10);
    check("ch2_pressed_fall", pressed_o, 4'b0000);
    check("ch2_led_still_on", led_o, 4'b0100);
    tick(1);
    check("ch2_led_off", led_o, 4'b0000);
    check("ch2_release", release_o, 4'b0100);

    // ch2 mode change: 1->0 holds LED, 0->1 follows pressed next cycle
    btn_i = 4'b1011;
    tick(11);
    check("ch2_led_on2", led_o, 4'b0100);
    mode_i = 4'b0000;
    btn_i  = 4'hF;
    tick(12);
    check("ch2_led_held", led_o, 4'b0100);
    mode_i = 4'b0100;
    tick(1);
    check("ch2_led_follow", led_o, 4'b0000);
    mode_i = 4'b0000;

    // ch0 and ch3 pressed in the same cycle
    btn_i = 4'b0110;
    tick(10);
    check("dual_pressed", pressed_o, 4'b1001);
    tick(1);
    check("dual_press", press_o, 4'b1001);
    check("dual_led", led_o, 4'b1001);
    btn_i = 4'hF;
    tick(12);
    check("dual_idle", pressed_o, 4'b0000);
    check("dual_led_hold", led_o, 4'b1001);

    // Reset mid-count on ch1, button held through reset release
    btn_i = 4'b1101;
    tick(6);
    rst = 1'b1;
    tick(1);
    check("midrst_led", led_o, 4'b0000);
    check("midrst_pressed", pressed_o, 4'b0000);
    check("midrst_press", press_o, 4'b0000);
    rst = 1'b0;
    tick(9);
    check("midrst_restart_pressed", pressed_o, 4'b0000);
    check("midrst_restart_press", press_o, 4'b0000);
    tick(1);
    check("midrst_new_pressed", pressed_o, 4'b0010);
    tick(1);
    check("midrst_new_press", press_o, 4'b0010);
    check("midrst_new_led", led_o, 4'b0010);

`ifdef LONG_PRESS_EN
    // Long press on ch1: one pulse 32 cycles after press_o, one toggle only
    btn_i = 4'hF;
    tick(12);
    check("long_pre_idle", pressed_o, 4'b0000);
    btn_i = 4'b1101;
    tick(11);
    check("long_press_evt", press_o, 4'b0010);
    check("long_led_toggle", led_o, 4'b0000);
    tick(31);
    check("long_early", long_press_o, 4'b0000);
    tick(1);
    check("long_pulse", long_press_o, 4'b0010);
    begin
      logic [3:0] extra;
      extra = 4'b0000;
      for (int i = 0; i < 17; i++) begin
        tick(1);
        extra = extra | long_press_o;
      end
      check("long_single", extra, 4'b0000);
    end
    check("long_led_once", led_o, 4'b0000);
    btn_i = 4'hF;
    tick(12);
    check("long_rel", pressed_o, 4'b0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
